// File: rtl/lifegame_gen_ctrl.sv
// Generation sequencer for a double-buffered life grid. Decisions are made on frame boundaries only, and every output is a flop.
// Request pulses are held as sticky flags until the next frame_end. The block never stalls and has no backpressure.
module lifegame_gen_ctrl #(
  parameter int H_LAST = 799,
  parameter int V_LAST = 524,
  parameter int GEN_W  = 16,
  parameter int DIV_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             reseed_req,
  input  logic [DIV_W-1:0] frame_div,
  output logic             bank_sel,
  output logic             seed_mode,
  output logic             wr_en_gen,
  output logic [GEN_W-1:0] gen_count,
  output logic             frame_tick,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_SEED  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             bank_q, bank_d;
  logic             seed_q, seed_d;
  logic             wr_q, wr_d;
  logic             tick_q, tick_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pend_rs_q, pend_rs_d;
  logic             pend_run_q, pend_run_d;
  logic             pend_step_q, pend_step_d;

  logic frame_end;
  logic rs_hit, run_hit, step_hit;

  assign frame_end = (h_count == 10'(H_LAST)) && (v_count == 10'(V_LAST));

  // A pulse landing on the frame_end cycle itself counts for this boundary.
  assign rs_hit   = pend_rs_q   | reseed_req;
  assign run_hit  = pend_run_q  | run_req;
  assign step_hit = pend_step_q | step_req;

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    wr_d        = wr_q;
    gen_d       = gen_q;
    div_d       = div_q;
    tick_d      = 1'b0;
    pend_rs_d   = rs_hit;
    pend_run_d  = run_hit;
    pend_step_d = step_hit;

    if (frame_end) begin
      pend_rs_d   = 1'b0;
      pend_run_d  = 1'b0;
      pend_step_d = 1'b0;

      if (wr_q) begin
        bank_d = ~bank_q;
        gen_d  = (state_q == ST_SEED) ? '0 : gen_q + GEN_W'(1);
        tick_d = 1'b1;
      end

      if (rs_hit) begin
        state_d = ST_SEED;
        wr_d    = 1'b1;
        div_d   = '0;
      end else begin
        case (state_q)
          ST_SEED: begin
            state_d = ST_RUN;
            wr_d    = 1'b1;
            div_d   = '0;
          end
          ST_RUN: begin
            if (run_hit) begin
              state_d = ST_PAUSE;
              wr_d    = 1'b0;
              div_d   = '0;
            end else if (div_q >= frame_div) begin
              div_d = '0;
              wr_d  = 1'b1;
            end else begin
              div_d = div_q + DIV_W'(1);
              wr_d  = 1'b0;
            end
          end
          ST_PAUSE: begin
            if (run_hit) begin
              state_d = ST_RUN;
              wr_d    = 1'b1;
              div_d   = '0;
            end else if (step_hit) begin
              state_d = ST_STEP;
              wr_d    = 1'b1;
            end else begin
              wr_d = 1'b0;
            end
          end
          default: begin
            // Run toggle out of a single step resumes free-running.
            if (run_hit) begin
              state_d = ST_RUN;
              wr_d    = 1'b1;
              div_d   = '0;
            end else begin
              state_d = ST_PAUSE;
              wr_d    = 1'b0;
            end
          end
        endcase
      end
    end

    seed_d = (state_d == ST_SEED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SEED;
      bank_q      <= 1'b0;
      seed_q      <= 1'b1;
      wr_q        <= 1'b1;
      tick_q      <= 1'b0;
      gen_q       <= '0;
      div_q       <= '0;
      pend_rs_q   <= 1'b0;
      pend_run_q  <= 1'b0;
      pend_step_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      seed_q      <= seed_d;
      wr_q        <= wr_d;
      tick_q      <= tick_d;
      gen_q       <= gen_d;
      div_q       <= div_d;
      pend_rs_q   <= pend_rs_d;
      pend_run_q  <= pend_run_d;
      pend_step_q <= pend_step_d;
    end
  end

  assign bank_sel   = bank_q;
  assign seed_mode  = seed_q;
  assign wr_en_gen  = wr_q;
  assign gen_count  = gen_q;
  assign frame_tick = tick_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lifegame_gen_ctrl.sv
// Bench for lifegame_gen_ctrl: short synthetic frames with a frame-level reference model and directed scenarios.
module tb_lifegame_gen_ctrl;

  localparam int SEED  = 0;
  localparam int RUN   = 1;
  localparam int PAUSE = 2;
  localparam int STEP  = 3;

  logic        clk;
  logic        rst;
  logic [9:0]  h_count, v_count;
  logic        run_req, step_req, reseed_req;
  logic [3:0]  frame_div;
  logic        bank_sel, seed_mode, wr_en_gen, frame_tick;
  logic [15:0] gen_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int t0;
  bit cmp_en = 0;

  lifegame_gen_ctrl dut (
    .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
    .run_req(run_req), .step_req(step_req), .reseed_req(reseed_req),
    .frame_div(frame_div), .bank_sel(bank_sel), .seed_mode(seed_mode),
    .wr_en_gen(wr_en_gen), .gen_count(gen_count), .frame_tick(frame_tick),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: what a controller must do at each boundary, from the rules.
  int m_state, m_gen, m_div;
  bit m_bank, m_wr, m_tick;
  bit want_rs, want_run, want_step;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = SEED; m_gen = 0; m_div = 0;
      m_bank = 0; m_wr = 1; m_tick = 0;
      want_rs = 0; want_run = 0; want_step = 0;
    end else begin
      want_rs   = want_rs   | reseed_req;
      want_run  = want_run  | run_req;
      want_step = want_step | step_req;
      m_tick = 0;
      if (h_count == 10'd799 && v_count == 10'd524) begin
        if (m_wr) begin
          m_bank = !m_bank;
          m_gen  = (m_state == SEED) ? 0 : (m_gen + 1) % 65536;
          m_tick = 1;
        end
        if (want_rs) begin
          m_state = SEED; m_wr = 1; m_div = 0;
        end else if (m_state == SEED) begin
          m_state = RUN; m_wr = 1; m_div = 0;
        end else if (m_state == RUN && want_run) begin
          m_state = PAUSE; m_wr = 0; m_div = 0;
        end else if (m_state == RUN) begin
          // one commit every frame_div+1 frames
          m_wr  = (m_div >= int'(frame_div));
          m_div = m_wr ? 0 : m_div + 1;
        end else if (want_run) begin
          m_state = RUN; m_wr = 1; m_div = 0;
        end else if (m_state == PAUSE && want_step) begin
          m_state = STEP; m_wr = 1;
        end else begin
          m_state = PAUSE; m_wr = 0;
        end
        want_rs = 0; want_run = 0; want_step = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state",      32'(state),      32'(m_state));
      check("bank_sel",   32'(bank_sel),   32'(m_bank));
      check("wr_en_gen",  32'(wr_en_gen),  32'(m_wr));
      check("seed_mode",  32'(seed_mode),  32'(m_state == SEED));
      check("gen_count",  32'(gen_count),  32'(m_gen[15:0]));
      check("frame_tick", 32'(frame_tick), 32'(m_tick));
      if (frame_tick === 1'b1) tick_cnt++;
    end
  end

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic [2:0] req);
    @(posedge clk); #1;
    h_count = h; v_count = v;
    reseed_req = req[2]; run_req = req[1]; step_req = req[0];
  endtask

  // req bits: {reseed, run, step}; includes near-miss and out-of-range counter values
  task automatic frame(input logic [2:0] mid, input logic [2:0] at_end);
    drive(10'd0,    10'd0,    3'b000);
    drive(10'd799,  10'd100,  mid);
    drive(10'd1023, 10'd1023, 3'b000);
    drive(10'd100,  10'd524,  3'b000);
    drive(10'd799,  10'd524,  at_end);
  endtask

  task automatic settle;
    drive(10'd5, 10'd5, 3'b000);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; h_count = '0; v_count = '0;
    run_req = 0; step_req = 0; reseed_req = 0; frame_div = 4'd0;
    repeat (3) @(posedge clk);
    cmp_en = 1;
    drive(10'd799, 10'd524, 3'b111);
    @(negedge clk); #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_wr", 32'(wr_en_gen), 32'd1);
    check("rst_seed", 32'(seed_mode), 32'd1);
    check("rst_bank", 32'(bank_sel), 32'd0);
    drive(10'd0, 10'd0, 3'b000);
    rst = 1'b1;

    frame(3'b000, 3'b000); settle;
    check("first_bank", 32'(bank_sel), 32'd1);
    check("first_gen", 32'(gen_count), 32'd0);
    check("first_state", 32'(state), 32'(RUN));
    check("first_tick", 32'(frame_tick), 32'd1);
    repeat (3) frame(3'b000, 3'b000);
    settle;
    check("div0_gen", 32'(gen_count), 32'd3);
    check("div0_bank", 32'(bank_sel), 32'd0);

    frame_div = 4'd2;
    t0 = tick_cnt;
    repeat (9) frame(3'b000, 3'b000);
    settle;
    check("div2_gen", 32'(gen_count), 32'd6);
    check("div2_ticks", 32'(tick_cnt - t0), 32'd3);
    frame_div = 4'd0;

    frame(3'b010, 3'b000); settle;
    check("pause_state", 32'(state), 32'(PAUSE));
    check("pause_wr", 32'(wr_en_gen), 32'd0);
    frame(3'b000, 3'b000);
    frame(3'b001, 3'b000); settle;
    check("step_state", 32'(state), 32'(STEP));
    t0 = tick_cnt;
    frame(3'b000, 3'b000); settle;
    check("step_gen", 32'(gen_count), 32'd8);
    check("step_back", 32'(state), 32'(PAUSE));
    check("step_ticks", 32'(tick_cnt - t0), 32'd1);

    frame(3'b000, 3'b001); settle;
    check("edge_step", 32'(state), 32'(STEP));
    frame(3'b000, 3'b000);
    frame(3'b010, 3'b000); settle;
    check("resume_gen", 32'(gen_count), 32'd9);
    check("resume_state", 32'(state), 32'(RUN));
    frame(3'b001, 3'b000);
    frame(3'b000, 3'b000); settle;
    check("run_step_gen", 32'(gen_count), 32'd11);
    check("run_step_state", 32'(state), 32'(RUN));

    frame(3'b010, 3'b000);
    frame(3'b111, 3'b000); settle;
    check("reseed_state", 32'(state), 32'(SEED));
    check("reseed_mode", 32'(seed_mode), 32'd1);
    check("reseed_gen", 32'(gen_count), 32'd12);
    frame(3'b000, 3'b000); settle;
    check("seed_gen0", 32'(gen_count), 32'd0);
    check("seed_run", 32'(state), 32'(RUN));
    check("seed_mode_off", 32'(seed_mode), 32'd0);

    repeat (5) frame(3'b000, 3'b000);
    settle;
    check("pre_rst_gen", 32'(gen_count), 32'd5);
    drive(10'd799, 10'd524, 3'b000);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_gen", 32'(gen_count), 32'd0);
    check("mid_rst_bank", 32'(bank_sel), 32'd0);
    check("mid_rst_state", 32'(state), 32'(SEED));
    @(negedge clk); #1;
    check("mid_rst_tick", 32'(frame_tick), 32'd0);
    check("mid_rst_bank2", 32'(bank_sel), 32'd0);
    drive(10'd3, 10'd3, 3'b111);
    drive(10'd4, 10'd4, 3'b000);
    rst = 1'b1;
    frame(3'b000, 3'b000); settle;
    check("rel_bank", 32'(bank_sel), 32'd1);
    check("rel_gen", 32'(gen_count), 32'd0);
    check("rel_state", 32'(state), 32'(RUN));

    repeat (2) @(posedge clk);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifegame_gen_ctrl.md
LIFEGAME_GEN_CTRL -- requirements
Module: lifegame_gen_ctrl

Interface
REQ-001 SHALL have parameters: H_LAST, 799, last h_count of a line; V_LAST, 524, last v_count of a frame; GEN_W, 16, generation counter width; DIV_W, 4, frame divider width.
REQ-002 SHALL have port clk  in  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have ports h_count  in  10 and v_count  in  10: VGA pixel counters, same timing as the datapath.
REQ-005 SHALL have ports run_req, step_req and reseed_req  in  1 each: single-cycle request pulses (run_req toggles run/pause).
REQ-006 SHALL have port frame_div  in  DIV_W  with N meaning one generation per N+1 frames while running.
REQ-007 SHALL have port bank_sel  out  1: read bank for the frame; the datapath writes the other bank.
REQ-008 SHALL have port seed_mode  out  1: 1 means write LFSR data and 0 means write the life-rule result.
REQ-009 SHALL have port wr_en_gen  out  1: 1 means the current frame is a commit frame and RAM writes are allowed.
REQ-010 SHALL have port gen_count  out  GEN_W: generations committed since the last seed.
REQ-011 SHALL have port frame_tick  out  1: one-cycle pulse after each committed frame.
REQ-012 SHALL have port state  out  2: SEED=0, RUN=1, PAUSE=2, STEP=3.

Function
REQ-013 SHALL define frame_end as h_count==H_LAST and v_count==V_LAST (exact match only); bank_sel, wr_en_gen, seed_mode, state and div_cnt SHALL change only on the edge ending a frame_end cycle.
REQ-014 SHALL latch each request pulse into a sticky pending flag; a pulse coincident with frame_end SHALL count for that boundary.
REQ-015 SHALL clear all pending flags at every frame_end, whether consumed or discarded.
REQ-016 SHALL apply these actions at frame_end when wr_en_gen==1: toggle bank_sel; set gen_count to 0 if state==SEED, else gen_count+1 (wrapping at 2^GEN_W); pulse frame_tick high for exactly the next cycle.
REQ-017 SHALL give pending requests the priority reseed > run toggle > step in every state.
REQ-018 SHALL on reseed pending at frame_end, from any state: go to SEED with wr_en_gen=1 and div_cnt=0.
REQ-019 SHALL at frame_end in SEED with no reseed: go to RUN with wr_en_gen=1 and div_cnt=0.
REQ-020 SHALL at frame_end in RUN, with run pending: go to PAUSE with wr_en_gen=0 and discard any step.
REQ-021 SHALL at frame_end in RUN, without run pending: set div_cnt=0 and wr_en_gen=1 if div_cnt>=frame_div, else div_cnt+1 and wr_en_gen=0 (frame_div sampled at frame_end; a lowered value takes effect at once).
REQ-022 SHALL at frame_end in PAUSE: on run pending go to RUN with wr_en_gen=1 and div_cnt=0; on step pending go to STEP with wr_en_gen=1; otherwise stay with wr_en_gen=0.
REQ-023 SHALL at frame_end in STEP: go to PAUSE with wr_en_gen=0, unless reseed or run is pending (REQ-017).
REQ-024 SHALL drive seed_mode=1 exactly when state==SEED.
REQ-025 SHALL drive all outputs from registers (no combinational path from inputs to outputs).
REQ-026 SHALL treat h_count/v_count values outside the frame range as non-frame_end, without error.

Reset
REQ-027 SHALL while rst==0 force state=SEED, seed_mode=1, wr_en_gen=1, bank_sel=0, gen_count=0, frame_tick=0, div_cnt=0 and all pending flags 0.
REQ-028 SHALL ignore requests during reset; release SHALL take effect at the first rising edge with rst==1, and a reset asserted mid-frame SHALL abandon that frame with no toggle and no tick.

Verification
REQ-029 SHALL verify: reset release, then 1st frame_end -> bank_sel 0->1, gen_count=0, state=RUN, frame_tick one cycle; frame_div=0 and 3 further frames -> gen_count=3, bank_sel=0.
REQ-030 SHALL verify: frame_div=2 in RUN over 9 frames -> wr_en_gen high on every 3rd frame only, gen_count +3, 3 ticks.
REQ-031 SHALL verify: run_req mid-frame in RUN -> PAUSE after frame_end, wr_en_gen=0; step_req -> exactly one commit frame (gen_count +1, one tick), then PAUSE.
REQ-032 SHALL verify: reseed_req, step_req and run_req in the same frame while in PAUSE -> SEED wins, seed_mode=1 for one frame, then gen_count=0 and RUN.
REQ-033 SHALL verify: step_req pulse coincident with the frame_end cycle in PAUSE -> STEP entered at that boundary; step_req in RUN -> discarded, no extra commit.
REQ-034 SHALL verify: rst asserted mid-frame in RUN with gen_count=5 -> outputs take reset values immediately, with no frame_tick and no bank toggle.
